// File: rtl/mbp_pkg.sv
// Shared types, constants and fixed-point helpers for the Mandelbrot pipeline.
// Optional build macro MBP_MUL_SAT_EN makes products and mag saturate instead of wrap.
package mbp_pkg;

  localparam int FRAC_BITS = 28;

  typedef logic signed [31:0] q4_28_t;

  localparam q4_28_t ONE       = 32'sh1000_0000;
  localparam q4_28_t ESCAPE_R2 = 32'sh4000_0000;
  localparam q4_28_t X_MIN     = 32'shE000_0000;
  localparam q4_28_t Y_MIN     = 32'shE800_0000;

  localparam int ST_W         = 81;
  localparam int ST_Y_LSB     = 49;
  localparam int ST_X_LSB     = 17;
  localparam int ST_DONE_BIT  = 16;
  localparam int ST_COUNT_LSB = 0;

  typedef struct packed {
    q4_28_t      y;
    q4_28_t      x;
    logic        done;
    logic [15:0] count;
  } mbp_state_t;

  typedef struct packed {
    q4_28_t xx;
    q4_28_t yy;
    q4_28_t xy;
    q4_28_t mag;
  } mbp_sq_t;

  typedef struct packed {
    q4_28_t xxsubyy;
    q4_28_t xy2;
  } mbp_diff_t;

  // Pixel pitch 3.0/res in Q4.28, truncated toward zero.
  function automatic q4_28_t q_step(int res);
    longint num;
    num = 3 * longint'(ONE);
    return q4_28_t'(num / longint'(res));
  endfunction

  function automatic q4_28_t q_mul(q4_28_t a, q4_28_t b);
    logic signed [63:0] p;
    p = (64'(a) * 64'(b)) >>> FRAC_BITS;
`ifdef MBP_MUL_SAT_EN
    if (p > 64'sh0000_0000_7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (p < -64'sh0000_0000_8000_0000) return 32'sh8000_0000;
`endif
    return q4_28_t'(p[31:0]);
  endfunction

  function automatic q4_28_t q_add_mag(q4_28_t a, q4_28_t b);
    logic signed [32:0] s;
    s = 33'(a) + 33'(b);
`ifdef MBP_MUL_SAT_EN
    if (s > 33'sh0_7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (s < -33'sh0_8000_0000) return 32'sh8000_0000;
`endif
    return q4_28_t'(s[31:0]);
  endfunction

  function automatic mbp_sq_t compute_0(q4_28_t x, q4_28_t y);
    mbp_sq_t r;
    r.xx  = q_mul(x, x);
    r.yy  = q_mul(y, y);
    r.xy  = q_mul(x, y);
    r.mag = q_add_mag(r.xx, r.yy);
    return r;
  endfunction

  function automatic mbp_diff_t compute_1(mbp_sq_t sq);
    mbp_diff_t r;
    r.xxsubyy = sq.xx - sq.yy;
    r.xy2     = sq.xy <<< 1;
    return r;
  endfunction

endpackage

// File: rtl/mandelbrot_pipe_if.sv
// Pixel stream bundle between the framebuffer and the Mandelbrot pipeline.
interface mandelbrot_pipe_if;
  import mbp_pkg::*;

  logic [10:0]     xin;
  logic [10:0]     yin;
  logic [ST_W-1:0] pin;
  logic [ST_W-1:0] pout;
  // output_ready: pout carries a valid pixel this cycle. There is no ready
  // input; the consumer must take every pixel, one per clock, no stalls.
  logic            output_ready;

  modport master (output xin, yin, pin, input pout, output_ready);
  modport slave  (input xin, yin, pin, output pout, output_ready);
endinterface

// File: rtl/mbp_square_step.sv
// Combinational z^2 terms: products/mag of the current z, and the
// difference/doubling terms of the products registered one stage earlier.
module mbp_square_step
  import mbp_pkg::*;
(
  input  q4_28_t    x,
  input  q4_28_t    y,
  output mbp_sq_t   sq,
  input  mbp_sq_t   sq_q,
  output mbp_diff_t diff
);

  assign sq   = compute_0(x, y);
  assign diff = compute_1(sq_q);

endmodule

// File: rtl/mandelbrot_pipe.sv
// Four-stage streaming z = z^2 + c engine, one pixel per clock.
// Build option MBP_MUL_SAT_EN selects saturating fixed-point products.
module mandelbrot_pipe
  import mbp_pkg::*;
#(
  parameter int RESX = 32,
  parameter int RESY = 32,
  parameter int IMAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mandelbrot_pipe_if.slave  bus
);

  localparam q4_28_t STEPX = q_step(RESX);
  localparam q4_28_t STEPY = q_step(RESY);

  mbp_state_t s1_state, s2_state, s3_state, s4_next;
  q4_28_t     s1_cre, s1_cim, s2_cre, s2_cim, s3_cre, s3_cim, s3_mag;
  mbp_sq_t    sq, s2_sq;
  mbp_diff_t  diff, s3_diff;
  logic       v1, v2, v3;

  mbp_square_step u_sq (
    .x    (s1_state.x),
    .y    (s1_state.y),
    .sq   (sq),
    .sq_q (s2_sq),
    .diff (diff)
  );

  always_comb begin
    s4_next = s3_state;
    if (!s3_state.done && s3_state.count < 16'(IMAX)) begin
      if (s3_mag > ESCAPE_R2) begin
        s4_next.done = 1'b1;
      end else begin
        s4_next.x     = s3_diff.xxsubyy + s3_cre;
        s4_next.y     = s3_diff.xy2 + s3_cim;
        s4_next.count = s3_state.count + 16'd1;
        s4_next.done  = 1'b0;
      end
    end
  end

  // Coordinates outside the frame map with the same formula; the multiply wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state         <= '0;
      s1_cre           <= '0;
      s1_cim           <= '0;
      s2_state         <= '0;
      s2_cre           <= '0;
      s2_cim           <= '0;
      s2_sq            <= '0;
      s3_state         <= '0;
      s3_cre           <= '0;
      s3_cim           <= '0;
      s3_mag           <= '0;
      s3_diff          <= '0;
      v1               <= 1'b0;
      v2               <= 1'b0;
      v3               <= 1'b0;
      bus.pout         <= '0;
      bus.output_ready <= 1'b0;
    end else begin
      s1_state.y     <= bus.pin[ST_Y_LSB +: 32];
      s1_state.x     <= bus.pin[ST_X_LSB +: 32];
      s1_state.done  <= bus.pin[ST_DONE_BIT];
      s1_state.count <= bus.pin[ST_COUNT_LSB +: 16];
      s1_cre         <= X_MIN + q4_28_t'(32'(bus.xin) * STEPX);
      s1_cim         <= Y_MIN + q4_28_t'(32'(bus.yin) * STEPY);

      s2_state <= s1_state;
      s2_cre   <= s1_cre;
      s2_cim   <= s1_cim;
      s2_sq    <= sq;

      s3_state <= s2_state;
      s3_cre   <= s2_cre;
      s3_cim   <= s2_cim;
      s3_mag   <= s2_sq.mag;
      s3_diff  <= diff;

      bus.pout <= s4_next;

      v1               <= 1'b1;
      v2               <= v1;
      v3               <= v2;
      bus.output_ready <= v3;
    end
  end

endmodule

// File: tb/tb_mandelbrot_pipe.sv
// Self-checking bench for mandelbrot_pipe: vector table, square-step unit,
// 1024-pixel stream and mid-stream reset, all through a latency-4 scoreboard.
module tb_mandelbrot_pipe;
  import mbp_pkg::*;

  localparam int RESX = 32;
  localparam int RESY = 32;
  localparam int IMAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mandelbrot_pipe_if bus ();

  mandelbrot_pipe #(.RESX(RESX), .RESY(RESY), .IMAX(IMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  q4_28_t    sq_x, sq_y;
  mbp_sq_t   sq_o;
  mbp_diff_t diff_o;

  mbp_square_step u_unit (
    .x    (sq_x),
    .y    (sq_y),
    .sq   (sq_o),
    .sq_q (sq_o),
    .diff (diff_o)
  );

  typedef struct {
    logic [10:0] xin;
    logic [10:0] yin;
    logic [80:0] pin;
    logic [80:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[11];
  logic [81:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          k_since_rst = 0;

  function automatic logic [80:0] mk(logic [31:0] y, logic [31:0] x, logic d, logic [15:0] c);
    return {y, x, d, c};
  endfunction

  function automatic logic [80:0] fresh(int x, int y);
    longint cre, cim;
    cre = -(longint'(2) <<< 28) + longint'(x) * ((longint'(3) <<< 28) / RESX);
    cim = -(longint'(3) <<< 27) + longint'(y) * ((longint'(3) <<< 28) / RESY);
    return {cim[31:0], cre[31:0], 1'b0, 16'd1};
  endfunction

  task automatic check(input string name, input logic [80:0] got, input logic [80:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Called on a negedge: compare the pixel driven four negedges ago, drive the next.
  task automatic step(input logic [10:0] x, input logic [10:0] y, input logic [80:0] p,
                      input logic [80:0] e, input logic chk, input string name);
    logic [81:0] front;
    string       fname;
    check("output_ready", {80'b0, bus.output_ready}, {80'b0, (k_since_rst >= 4)});
    if (exp_q.size() == 4) begin
      front = exp_q.pop_front();
      fname = name_q.pop_front();
      if (front[81]) check(fname, bus.pout, front[80:0]);
    end
    bus.xin = x;
    bus.yin = y;
    bus.pin = p;
    exp_q.push_back({chk, e});
    name_q.push_back(name);
    k_since_rst++;
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(11'd0, 11'd0, '0, '0, 1'b0, "flush");
  endtask

  task automatic start_after_reset();
    rst_n = 1'b1;
    k_since_rst = 0;
    exp_q.delete();
    name_q.delete();
  endtask

  initial begin
    vecs[0]  = '{11'd0,  11'd0,  '0, mk(32'hE800_0000, 32'hE000_0000, 1'b0, 16'd1), "fresh_origin"};
    vecs[1]  = '{11'd0,  11'd0,  mk(32'hE800_0000, 32'hE000_0000, 1'b0, 16'd1),
                 mk(32'hE800_0000, 32'hE000_0000, 1'b1, 16'd1), "escape"};
    vecs[2]  = '{11'd0,  11'd0,  mk(32'h0, 32'h0, 1'b0, 16'd8), mk(32'h0, 32'h0, 1'b0, 16'd8), "imax_hold"};
    vecs[3]  = '{11'd0,  11'd16, mk(32'h0, 32'h0, 1'b0, 16'd3),
                 mk(32'h0, 32'hE000_0000, 1'b0, 16'd4), "cim_zero"};
    vecs[4]  = '{11'd0,  11'd0,  mk(32'h0, 32'h1000_0000, 1'b1, 16'd2),
                 mk(32'h0, 32'h1000_0000, 1'b1, 16'd2), "done_hold"};
    vecs[5]  = '{11'd16, 11'd16, mk(32'h0, 32'h0, 1'b0, 16'd7),
                 mk(32'h0, 32'hF800_0000, 1'b0, 16'd8), "reach_imax"};
    vecs[6]  = '{11'd16, 11'd16, mk(32'h0, 32'h2000_0000, 1'b0, 16'd2),
                 mk(32'h0, 32'h3800_0000, 1'b0, 16'd3), "mag_eq_4"};
    vecs[7]  = '{11'd16, 11'd16, mk(32'h0800_0000, 32'h1800_0000, 1'b0, 16'd5),
                 mk(32'h1800_0000, 32'h1800_0000, 1'b0, 16'd6), "iter_pos"};
    vecs[8]  = '{11'd0,  11'd0,  mk(32'h0800_0000, 32'hF000_0000, 1'b0, 16'd1),
                 mk(32'hD800_0000, 32'hEC00_0000, 1'b0, 16'd2), "iter_neg"};
    vecs[9]  = '{11'd40, 11'd40, '0, mk(32'h2400_0000, 32'h1C00_0000, 1'b0, 16'd1), "out_of_range"};
`ifdef MBP_MUL_SAT_EN
    vecs[10] = '{11'd16, 11'd16, mk(32'h7000_0000, 32'h7000_0000, 1'b0, 16'd1),
                 mk(32'h7000_0000, 32'h7000_0000, 1'b1, 16'd1), "big_z"};
`else
    vecs[10] = '{11'd16, 11'd16, mk(32'h7000_0000, 32'h7000_0000, 1'b0, 16'd1),
                 mk(32'h2000_0000, 32'hF800_0000, 1'b0, 16'd2), "big_z"};
`endif

    // Reset held with stimulus toggling.
    rst_n   = 1'b0;
    bus.xin = '0;
    bus.yin = '0;
    bus.pin = '0;
    sq_x    = '0;
    sq_y    = '0;
    repeat (5) begin
      @(negedge clk);
      bus.xin = 11'($urandom_range(0, 2047));
      bus.yin = 11'($urandom_range(0, 2047));
      bus.pin = {17'($urandom), $urandom, $urandom};
      check("reset_pout", bus.pout, '0);
      check("reset_ready", {80'b0, bus.output_ready}, '0);
    end

    @(negedge clk);
    start_after_reset();
    foreach (vecs[i]) step(vecs[i].xin, vecs[i].yin, vecs[i].pin, vecs[i].exp, 1'b1, vecs[i].name);
    flush();

    sq_x = 32'sh1800_0000;
    sq_y = 32'sh0800_0000;
    #1;
    check("unit_xx",      {49'b0, sq_o.xx},        {49'b0, 32'h2400_0000});
    check("unit_yy",      {49'b0, sq_o.yy},        {49'b0, 32'h0400_0000});
    check("unit_xy",      {49'b0, sq_o.xy},        {49'b0, 32'h0C00_0000});
    check("unit_mag",     {49'b0, sq_o.mag},       {49'b0, 32'h2800_0000});
    check("unit_xxsubyy", {49'b0, diff_o.xxsubyy}, {49'b0, 32'h2000_0000});
    check("unit_xy2",     {49'b0, diff_o.xy2},     {49'b0, 32'h1800_0000});
`ifdef MBP_MUL_SAT_EN
    sq_x = 32'sh7000_0000;
    sq_y = 32'sh7000_0000;
    #1;
    check("unit_sat_xx",  {49'b0, sq_o.xx},  {49'b0, 32'h7FFF_FFFF});
    check("unit_sat_mag", {49'b0, sq_o.mag}, {49'b0, 32'h7FFF_FFFF});
`endif
    @(negedge clk);

    for (int i = 0; i < 1024; i++)
      step(11'(i % RESX), 11'(i / RESX), '0, fresh(i % RESX, i / RESX), 1'b1, "stream");
    flush();

    // Asynchronous reset mid-stream drops in-flight pixels at once.
    step(11'd3, 11'd5, '0, '0, 1'b0, "inflight");
    step(11'd7, 11'd9, '0, '0, 1'b0, "inflight");
    #2 rst_n = 1'b0;
    #1;
    check("midreset_pout", bus.pout, '0);
    check("midreset_ready", {80'b0, bus.output_ready}, '0);
    @(negedge clk);
    start_after_reset();
    step(11'd5, 11'd7, '0, fresh(5, 7), 1'b1, "after_reset");
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pipe.md
Name: mandelbrot_pipe

Overview:
- Streaming, fully pipelined Mandelbrot iteration engine that accepts one pixel per clock.
- Each pixel's coordinate (xin, yin) is mapped to a complex constant c.
- One z = z² + c iteration is applied to the 81-bit per-pixel state pin, and the updated state is emitted on pout.
- The surrounding framebuffer feeds pout back as pin on the next frame pass, so iteration count grows by at most one per pass until escape or IMAX.

Parameters:
- RESX, 32, horizontal resolution in pixels (≥2).
- RESY, 32, vertical resolution in pixels (≥2).
- IMAX, 8, iteration cap (1..65535).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- xin  in  11  pixel column, 0..RESX-1.
- yin  in  11  pixel row, 0..RESY-1.
- pin  in  81  incoming pixel state; all-zero means a fresh pixel.
- pout  out  81  updated pixel state.
- output_ready  out  1  pout holds valid data this cycle.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- State layout, used for both pin and pout:
  - [80:49] y (imag z)
  - [48:17] x (real z)
  - [16] done (escaped)
  - [15:0] count
- Number format: signed fixed-point Q4.28, 32 bits; 1.0 = 0x1000_0000.
- Coordinate map:
  - c_re = -2.0 + xin·STEPX, with STEPX = 3.0/RESX computed at elaboration in Q4.28.
  - c_im = -1.5 + yin·STEPY, with STEPY = 3.0/RESY.
- Fixed-point multiply: 64-bit signed product, arithmetic shift right 28, keep the low 32 bits (wraps).
- Stage 1: register pin, c_re and c_im.
- Stage 2 (compute_0 function):
  - xx = x·x, yy = y·y, xy = x·y.
  - mag = xx + yy, computed from the same products.
- Stage 3 (compute_1 function): xxsubyy = xx − yy; xy2 = xy << 1.
- Stage 4, output register:
  - If done=1 or count ≥ IMAX: state passes through unchanged.
  - Else if mag > 4.0 (0x4000_0000, signed compare): set done=1; x, y and count unchanged.
  - Else: x = xxsubyy + c_re; y = xy2 + c_im; count = count + 1; done = 0.
- Latency: exactly 4 clocks from input sample edge to pout; throughput 1 pixel/clock; no stall or backpressure.
- output_ready is 0 during reset and rises on the 4th rising edge after rst_n deasserts. It then stays 1 until the next reset.
- Reset: pout = 0, output_ready = 0, all pipeline registers cleared. Reset asserted mid-stream discards in-flight pixels immediately.
- xin ≥ RESX or yin ≥ RESY: mapped with the same formula; no clamping.
- Pixel (or pin) changes on consecutive cycles are independent; no cross-pixel hazards.

Optional Feature:
- Macro MBP_MUL_SAT_EN.
- When defined: each Q4.28 product saturates to 0x7FFF_FFFF / 0x8000_0000 if the shifted 64-bit result exceeds the 32-bit range, and mag saturates the same way.
- When undefined: products wrap, as described in Behaviour.
- Latency is identical in both builds.

Decomposition:
- Shared package mbp_pkg holds:
  - Q4.28 typedef and constant FRAC_BITS = 28.
  - Constants ONE, ESCAPE_R2 = 4.0, X_MIN = -2.0, Y_MIN = -1.5.
  - Field offsets of the 81-bit state.
  - Packed state struct.
- One natural sub-module, mbp_square_step: combinational xx/yy/xy followed by xxsubyy/xy2. The top module registers around it.

Test Plan:
- Reset held 5 cycles with stimulus toggling → pout = 0 and output_ready = 0. After release, output_ready first = 1 exactly 4 edges later.
- RESX = RESY = 32; xin=0, yin=0, pin=0 → 4 cycles later: x=0xE000_0000, y=0xE800_0000, done=0, count=1.
- Feed that result back as pin at xin=0, yin=0 (mag = 6.25) → done=1, count=1, x/y unchanged.
- Square-step unit with x=1.5 (0x1800_0000), y=0.5 (0x0800_0000) → xx=0x2400_0000, yy=0x0400_0000, xy=0x0C00_0000, xxsubyy=0x2000_0000, xy2=0x1800_0000.
- pin with count=8 (IMAX), done=0, z=0 → pout equals pin. Pixel xin=0, yin=16 (c_im = 0) with z=0, count=3 → x=0xE000_0000, y=0, count=4.
- Streaming: 1024 consecutive pixels, one per clock, with pin=0 → every pout equals c(xin, yin) with count=1, in input order, no gaps. With MBP_MUL_SAT_EN, x=y=0x7000_0000 → xx and mag saturate to 0x7FFF_FFFF and done is set.
